// File: rtl/irq_pending_unit.sv
// Interrupt pending stage ahead of daisy_chain: synchronises raw request lines,
// captures them as level or rising-edge latched, and tracks lost edge events.
module irq_pending_unit #(
  parameter int N_IRQ       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_raw_i,
  input  logic [N_IRQ-1:0] edge_sel_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic [N_IRQ-1:0] irq_ret_i,
  input  logic             csr_clr_we_i,
  input  logic [N_IRQ-1:0] csr_clr_i,
  output logic [N_IRQ-1:0] masked_irq_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] lost_o
);

  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_lost;

  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_clr_csr;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic [N_IRQ-1:0] w_new_lost;
  logic [N_IRQ-1:0] w_lost_nxt;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_prev;
  assign w_clr_csr = {N_IRQ{csr_clr_we_i}} & csr_clr_i;
  assign w_clr     = irq_ret_i | w_clr_csr;

  // Per-line next state: a set in edge mode beats a same-cycle clear so no event is dropped
  always_comb begin
    w_pending_nxt = r_pending;
    w_new_lost    = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (edge_sel_i[k]) begin
        if (w_rise[k]) begin
          w_pending_nxt[k] = 1'b1;
        end else if (w_clr[k]) begin
          w_pending_nxt[k] = 1'b0;
        end else begin
          w_pending_nxt[k] = r_pending[k];
        end
        w_new_lost[k] = w_rise[k] & r_pending[k] & ~w_clr[k];
      end else begin
        w_pending_nxt[k] = w_s[k];
        w_new_lost[k]    = 1'b0;
      end
    end
    w_lost_nxt = (r_lost & ~w_clr_csr) | w_new_lost;
  end

  // Synchroniser chain, edge history and pending/lost state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev    <= '0;
      r_pending <= '0;
      r_lost    <= '0;
    end else begin
      r_sync[0] <= irq_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev    <= w_s;
      r_pending <= w_pending_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  assign pending_o    = r_pending;
  assign lost_o       = r_lost;
  assign masked_irq_o = r_pending & mie_i;

endmodule
